// File: rtl/multicycle_cu.sv
// Purpose     : Moore FSM control unit sequencing a shared ALU/memory RV32I-subset datapath.
// Latency     : LD 5, ST 4, R/I 4, B 3 cycles from FETCH with no stalls; HLT reaches HALT after 2.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold on mem_ready=0; watchdog halts with sticky fault.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   opcode/funct3/funct7  instruction fields from IR (funct7 = IR[30])
//   zero, sign            ALU flags for the current cycle
//   mem_ready             memory completes the access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ImmSrc, ALUControl, RegWrite  datapath controls (combinational)
//   halted, fault, state  status / debug
module multicycle_cu #(
   parameter int MEM_TIMEOUT = 255,
   parameter int TW          = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7,
   input  logic       zero,
   input  logic       sign,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       RegWrite,
   output logic       halted,
   output logic       fault,
   output logic [3:0] state
);

   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_HLT = 7'b0000000;

   localparam bit          WD_EN       = (MEM_TIMEOUT != 0);
   localparam logic [TW-1:0] TIMEOUT_VAL = TW'(MEM_TIMEOUT);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_HALT     = 4'd10
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;
   logic          fault_q, fault_d;
   logic          in_wait;

   // raw (ungated) enables and internal ALU op class
   logic       pc_write, mem_write, ir_write, reg_write;
   logic [1:0] alu_op;
   logic       taken;

   assign wait_cnt_inc = wait_cnt_q + 1'b1;
   assign in_wait      = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                         (state_q == S_MEMWRITE);

   // ------------------------------------------------------------------
   // Next state, wait counter and sticky fault
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      fault_d    = fault_q;
      wait_cnt_d = '0;

      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LD, OP_ST: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_B:         state_d = S_BRANCH;
               OP_HLT:       state_d = S_HALT;
               default:      state_d = S_FETCH;  // unknown opcode acts as NOP
            endcase
         end
         S_MEMADR:   state_d = (opcode == OP_ST) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_FETCH;
      endcase

      // Counter only survives while stalled; a granted mem_ready always
      // takes the normal transition, even on the cycle the limit is hit.
      if (in_wait && !mem_ready) begin
         wait_cnt_d = wait_cnt_inc;
         if (WD_EN && (wait_cnt_inc == TIMEOUT_VAL)) begin
            state_d    = S_HALT;
            fault_d    = 1'b1;
            wait_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         fault_q    <= fault_d;
      end
   end

   // ------------------------------------------------------------------
   // Branch condition from {funct3[2], funct3[0]}
   // ------------------------------------------------------------------
   always_comb begin
      taken = 1'b0;
      case ({funct3[2], funct3[0]})
         2'b00:   taken = zero;   // beq
         2'b01:   taken = ~zero;  // bne
         2'b10:   taken = sign;   // blt
         default: taken = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Per-state datapath controls (Moore, plus mem_ready/taken gating)
   // ------------------------------------------------------------------
   always_comb begin
      pc_write  = 1'b0;
      AdrSrc    = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ImmSrc    = 2'b00;
      reg_write = 1'b0;
      alu_op    = 2'b00;

      case (state_q)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            // branch target PC_old + imm parked in ALUOut
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = 2'b10;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = (opcode == OP_ST) ? 2'b01 : 2'b00;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            reg_write = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b00;
            alu_op  = 2'b10;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = 2'b00;
            alu_op  = 2'b10;
         end
         S_ALUWB: begin
            ResultSrc = 2'b00;
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            // ALUResult only feeds the flags; PC is loaded from ALUOut
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b00;
            alu_op    = 2'b01;
            ResultSrc = 2'b00;
            pc_write  = taken;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // ALU decode
   // ------------------------------------------------------------------
   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         2'b00: ALUControl = 3'b000;
         2'b01: begin
            if ((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100))
               ALUControl = 3'b010;
            else
               ALUControl = 3'b000;
         end
         default: begin
            // funct7 only selects sub for register-register ops (opcode[5]=1)
            if (funct3 == 3'b000)
               ALUControl = (opcode[5] & funct7) ? 3'b010 : 3'b000;
            else
               ALUControl = funct3;
         end
      endcase
   end

   // Architectural enables are killed directly by rst so a store in flight
   // drops its strobe without waiting for a clock edge.
   assign PCWrite  = pc_write  & ~rst;
   assign MemWrite = mem_write & ~rst;
   assign IRWrite  = ir_write  & ~rst;
   assign RegWrite = reg_write & ~rst;

   assign halted = (state_q == S_HALT);
   assign fault  = fault_q;
   assign state  = state_q;

endmodule

// File: tb/tb_multicycle_cu.sv
module tb_multicycle_cu;

   logic       clk, rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7, zero, sign, mem_ready;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, halted, fault;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;

   multicycle_cu #(.MEM_TIMEOUT(4), .TW(8)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .zero(zero), .sign(sign), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .RegWrite(RegWrite), .halted(halted), .fault(fault),
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, adr, memw, irw;
      logic [1:0] res, srca, srcb, imm;
      logic [2:0] aluc;
      logic       regw, hlt, flt;
   } obs_t;

   obs_t got;
   assign got = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ImmSrc, ALUControl, RegWrite, halted, fault};

   obs_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic exp_fault = 1'b0;

   localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011,
                          IT = 7'b0010011, BT = 7'b1100011, HL = 7'b0000000,
                          BAD = 7'b1111111;

   // Expected controls for a given state, straight from the state table.
   function automatic obs_t exp_out(logic [3:0] st, logic [6:0] op, logic [2:0] f3,
                                    logic f7, logic z, logic s, logic mr, logic flt);
      obs_t e;
      e = '0;
      e.st  = st;
      e.flt = flt;
      case (st)
         4'd0: begin e.srcb = 2'b10; e.res = 2'b10; e.pcw = mr; e.irw = mr; end
         4'd1: begin e.srca = 2'b01; e.srcb = 2'b01; e.imm = 2'b10; end
         4'd2: begin e.srca = 2'b10; e.srcb = 2'b01; e.imm = (op == ST) ? 2'b01 : 2'b00; end
         4'd3: e.adr = 1'b1;
         4'd4: begin e.res = 2'b01; e.regw = 1'b1; end
         4'd5: begin e.adr = 1'b1; e.memw = 1'b1; end
         4'd6, 4'd7: begin
            e.srca = 2'b10;
            e.srcb = (st == 4'd7) ? 2'b01 : 2'b00;
            if (f3 != 3'b000)              e.aluc = f3;
            else if (op == RT && f7)       e.aluc = 3'b010;  // sub
            else                           e.aluc = 3'b000;  // add / addi
         end
         4'd8: e.regw = 1'b1;
         4'd9: begin
            e.srca = 2'b10;
            case (f3)
               3'b000:  begin e.aluc = 3'b010; e.pcw = z;  end  // beq
               3'b001:  begin e.aluc = 3'b010; e.pcw = !z; end  // bne
               3'b100:  begin e.aluc = 3'b010; e.pcw = s;  end  // blt
               default: begin e.aluc = 3'b000; e.pcw = 1'b0; end
            endcase
         end
         4'd10: e.hlt = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   // One cycle: drive at the falling edge, queue expectation, compare 1ns later.
   task automatic apply(input string tag, input logic [3:0] st, input logic [6:0] op,
                        input logic [2:0] f3, input logic f7, input logic z,
                        input logic s, input logic mr);
      obs_t e;
      opcode = op; funct3 = f3; funct7 = f7; zero = z; sign = s; mem_ready = mr;
      sb_q.push_back(exp_out(st, op, f3, f7, z, s, mr, exp_fault));
      #1;
      e = sb_q.pop_front();
      vectors++;
      assert (got === e) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, e);
      end
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Asynchronous reset pulse starting mid-cycle; returns at a falling edge.
   task automatic pulse_rst(input string tag);
      #2 rst = 1'b1;
      #1;
      chk({tag, "_state"}, 8'(state), 8'd0);
      chk({tag, "_fault"}, 8'(fault), 8'd0);
      chk({tag, "_memw"},  8'(MemWrite), 8'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_fault = 1'b0;
   endtask

   initial begin
      rst = 1'b1; opcode = '0; funct3 = '0; funct7 = 1'b0;
      zero = 1'b0; sign = 1'b0; mem_ready = 1'b1;
      #3;
      @(posedge clk); #1;
      chk("rst_state", 8'(state), 8'd0);
      chk("rst_fault", 8'(fault), 8'd0);
      chk("rst_pcw_forced", 8'(PCWrite), 8'd0);
      chk("rst_irw_forced", 8'(IRWrite), 8'd0);
      @(negedge clk);
      rst = 1'b0;

      // R-type add then sub
      apply("add_fetch",  0, RT, 3'b000, 0, 0, 0, 1);
      apply("add_decode", 1, RT, 3'b000, 0, 0, 0, 1);
      apply("add_execr",  6, RT, 3'b000, 0, 0, 0, 1);
      apply("add_aluwb",  8, RT, 3'b000, 0, 0, 0, 1);
      apply("sub_fetch",  0, RT, 3'b000, 1, 0, 0, 1);
      apply("sub_decode", 1, RT, 3'b000, 1, 0, 0, 1);
      apply("sub_execr",  6, RT, 3'b000, 1, 0, 0, 1);
      apply("sub_aluwb",  8, RT, 3'b000, 1, 0, 0, 1);

      // LD with three stall cycles in MEMREAD
      apply("ld_fetch",  0, LD, 3'b010, 0, 0, 0, 1);
      apply("ld_decode", 1, LD, 3'b010, 0, 0, 0, 1);
      apply("ld_memadr", 2, LD, 3'b010, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++)
         apply("ld_memread_stall", 3, LD, 3'b010, 0, 0, 0, 0);
      apply("ld_memread_done", 3, LD, 3'b010, 0, 0, 0, 1);
      apply("ld_memwb", 4, LD, 3'b010, 0, 0, 0, 1);

      // Branches: beq zero=1, bne zero=1, blt sign=1
      apply("beq_fetch",  0, BT, 3'b000, 0, 1, 0, 1);
      apply("beq_decode", 1, BT, 3'b000, 0, 1, 0, 1);
      apply("beq_branch", 9, BT, 3'b000, 0, 1, 0, 1);
      apply("bne_fetch",  0, BT, 3'b001, 0, 1, 0, 1);
      apply("bne_decode", 1, BT, 3'b001, 0, 1, 0, 1);
      apply("bne_branch", 9, BT, 3'b001, 0, 1, 0, 1);
      apply("blt_fetch",  0, BT, 3'b100, 0, 0, 1, 1);
      apply("blt_decode", 1, BT, 3'b100, 0, 0, 1, 1);
      apply("blt_branch", 9, BT, 3'b100, 0, 0, 1, 1);

      // I-type: funct7 must not turn addi into sub; andi passes funct3
      apply("addi_fetch",  0, IT, 3'b000, 1, 0, 0, 1);
      apply("addi_decode", 1, IT, 3'b000, 1, 0, 0, 1);
      apply("addi_execi",  7, IT, 3'b000, 1, 0, 0, 1);
      apply("addi_aluwb",  8, IT, 3'b000, 1, 0, 0, 1);
      apply("andi_fetch",  0, IT, 3'b111, 0, 0, 0, 1);
      apply("andi_decode", 1, IT, 3'b111, 0, 0, 0, 1);
      apply("andi_execi",  7, IT, 3'b111, 0, 0, 0, 1);
      apply("andi_aluwb",  8, IT, 3'b111, 0, 0, 0, 1);

      // mem_ready arrives on the cycle the limit would trip; then unknown opcode
      for (int i = 0; i < 3; i++)
         apply("fetch_stall", 0, BAD, 3'b000, 0, 0, 0, 0);
      apply("fetch_ready_wins", 0, BAD, 3'b000, 0, 0, 0, 1);
      apply("nop_decode", 1, BAD, 3'b000, 0, 0, 0, 1);
      apply("nop_back_fetch", 0, BAD, 3'b000, 0, 0, 0, 0);
      chk("no_fault_after_ready", 8'(fault), 8'd0);
      apply("nop_fetch2", 0, BAD, 3'b000, 0, 0, 0, 1);
      apply("nop_decode2", 1, BAD, 3'b000, 0, 0, 0, 1);

      // ST, stall in MEMWRITE, async reset mid-cycle
      apply("st_fetch",  0, ST, 3'b010, 0, 0, 0, 1);
      apply("st_decode", 1, ST, 3'b010, 0, 0, 0, 1);
      apply("st_memadr", 2, ST, 3'b010, 0, 0, 0, 1);
      apply("st_memwrite", 5, ST, 3'b010, 0, 0, 0, 0);
      #1;
      chk("st_memw_before_rst", 8'(MemWrite), 8'd1);
      chk("st_state_before_rst", 8'(state), 8'd5);
      pulse_rst("st_rst");
      apply("after_st_rst", 0, ST, 3'b010, 0, 0, 0, 0);

      // HLT: halt after DECODE, stays put with mem_ready toggling
      apply("hlt_fetch",  0, HL, 3'b000, 0, 0, 0, 1);
      apply("hlt_decode", 1, HL, 3'b000, 0, 0, 0, 1);
      for (int i = 0; i < 11; i++)
         apply("hlt_hold", 10, HL, 3'b000, 0, 0, 0, 1'(i));
      pulse_rst("hlt_rst");

      // Watchdog: 4 stalled FETCH cycles -> HALT with fault
      for (int i = 0; i < 4; i++)
         apply("wd_fetch_stall", 0, RT, 3'b000, 0, 0, 0, 0);
      exp_fault = 1'b1;
      for (int i = 0; i < 3; i++)
         apply("wd_halt", 10, RT, 3'b000, 0, 0, 0, 1'(i));
      pulse_rst("wd_rst");
      apply("wd_after_rst", 0, RT, 3'b000, 0, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
